bist_controller: RTL and testbench
==================================

# bist_controller

On-chip BIST responder for the `chip` wrapper: it answers the bench's `bistmode`/`rst` start sequence by driving pseudo-random patterns onto the CUT primary inputs and compacting the CUT primary outputs into a MISR signature. It then raises `bistdone` with `bistpass` indicating a signature match against a golden value. It sits between the chip pins and the CUT, muxing `pi` onto the CUT inputs in system mode.

## Interface

- `PI_W`, 35, CUT primary-input width.
- `PO_W`, 49, CUT primary-output width.
- `NUM_PATTERNS`, 2000, patterns applied per run. Legal range 1..65535.
- `LFSR_SEED`, 35'h1, LFSR load value. Zero is illegal; it is replaced by all-ones.
- `GOLDEN_SIG`, 49'h0, expected MISR signature, taken from fault-free simulation.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `bistmode` input 1: 1 requests a BIST run; 0 selects system mode.
- `pi` input PI_W: functional primary inputs from the pins.
- `cut_pi` output PI_W: CUT inputs. Equals `pi` in system mode and the LFSR state in RUN.
- `cut_po` input PO_W: CUT primary outputs.
- `bistdone` output 1: run complete. Registered.
- `bistpass` output 1: signature matched. Registered, valid while `bistdone`=1.

## Operation

- The state machine has five states: IDLE, INIT, RUN, COMPARE, DONE.
- **IDLE**
  - `cut_pi`=`pi`.
  - `bistmode`=1 → INIT.
- **INIT**
  - LFSR ← `LFSR_SEED`, or all-ones if the seed is 0.
  - MISR ← 0; counter ← 0.
  - Next state: RUN.
- **RUN**
  - `cut_pi`=LFSR state.
  - Every edge:
    - LFSR ← {lfsr[33:0], lfsr[34]^lfsr[32]} (x^35+x^33+1, maximal length).
    - MISR ← {misr[47:0], misr[48]^misr[39]} ^ `cut_po` (x^49+x^40+1).
    - counter+1.
  - Leave RUN on the edge where counter == NUM_PATTERNS-1 (that edge still captures) → COMPARE.
- **COMPARE**
  - LFSR and MISR hold.
  - On exit: `bistpass` ← (MISR == GOLDEN_SIG), `bistdone` ← 1 → DONE.
- **DONE**
  - `bistdone` and `bistpass` hold.
  - `cut_pi`=`pi`.
  - `bistmode`=0 → IDLE, which clears `bistdone`/`bistpass`.
  - A new run requires `bistmode` low then high, or a reset.
- **`bistmode` drop in INIT/RUN/COMPARE:** abort to IDLE; `bistdone` stays 0 and the partial signature is discarded.
- **Counter:** 16 bits, no wrap; counting stops in COMPARE.

## Timing

- **Reset values:** state=IDLE, LFSR=all-ones, MISR=0, counter=0, `bistdone`=0, `bistpass`=0, `cut_pi`=`pi` (combinational mux).
- **Reset mid-run:** immediate return to IDLE; outputs go to their reset values asynchronously.
- **Start:** let E0 be the first rising edge, with `rst` high, that samples `bistmode`=1 in IDLE.
  - E0 → INIT; E1 → RUN.
  - MISR captures at E2..E(N+1).
  - `bistdone` rises at E(N+2), a latency of N+2 cycles from E0.
- **Pattern timing:** RUN cycle k (between edges E(k+1) and E(k+2)) presents LFSR pattern k. `cut_po` must settle within that cycle; it is compacted at its closing edge.
- **Outputs:** `bistdone` and `bistpass` change only on `clk` edges or on reset assertion.

## Configuration

- **`BIST_SIGOUT_EN`**
  - Defined: adds output port `bistsig` [PO_W-1:0], driving the live MISR value, for signature diagnosis and for extracting `GOLDEN_SIG` from fault-free runs.
  - Undefined: the port is absent; MISR is internal only.
  - Compaction behaviour is identical either way.

## Test plan

- **Reset/system mode:** `rst`=0 with any `bistmode` → `bistdone`=0, `bistpass`=0. With `bistmode`=0, `pi`=35'h5A5A5A5A5 → `cut_pi`=35'h5A5A5A5A5.
- **Fault-free run:** N=4, seed=1, `cut_po`={14'b0,`cut_pi`}, GOLDEN_SIG=0.
  - `cut_pi` sequence 1, 2, 4, 8.
  - MISR 1, 0, 4, 0.
  - `bistdone`=1 at E6 with `bistpass`=1.
- **Stuck-at fault:** same setup with `cut_po[0]` forced to 1 → MISR 1, 1, 7, 7; `bistdone`=1 at E6 with `bistpass`=0.
- **Golden mismatch:** fault-free run with GOLDEN_SIG=1 → `bistpass`=0.
- **Abort and reset:**
  - `bistmode` dropped in RUN cycle 2 → state IDLE; `bistdone` never rises.
  - Re-raising `bistmode` → a full fresh run, identical to the fault-free run result.
  - `rst` pulsed low mid-RUN → same outcome.
- **Back-to-back runs:** two consecutive runs at default parameters (`bistmode` low for 1 cycle between) → identical signatures and `bistpass`. Seed 0 behaves identically to seed all-ones.

Source files
------------

// File: rtl/bist_controller.sv
// Purpose     : BIST responder. It drives LFSR patterns onto the CUT inputs and compacts the CUT outputs
//               into a MISR, then compares the result with a golden signature.
// Latency     : bistdone rises NUM_PATTERNS+2 cycles after the edge that samples bistmode=1 in IDLE.
// Backpressure: none. Dropping bistmode before DONE aborts the run and discards the partial signature.
//
// Ports:
//   clk, rst (async active-low)
//   bistmode       : 1 requests a run, 0 selects system mode
//   pi -> cut_pi   : pin pass-through, or the LFSR state while in RUN
//   cut_po         : CUT outputs, compacted into the MISR
//   bistdone, bistpass : registered run result
// Optional build macro BIST_SIGOUT_EN adds output bistsig, which carries the live MISR value.
// Feedback taps are x^35+x^33+1 (LFSR) and x^49+x^40+1 (MISR), placed relative to PI_W / PO_W.
module bist_controller #(
    parameter int              PI_W         = 35,
    parameter int              PO_W         = 49,
    parameter int              NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0] LFSR_SEED    = {{(PI_W-1){1'b0}}, 1'b1},
    parameter logic [PO_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi,
    output logic [PI_W-1:0] cut_pi,
    input  logic [PO_W-1:0] cut_po,
    output logic            bistdone,
    output logic            bistpass
`ifdef BIST_SIGOUT_EN
    ,
    output logic [PO_W-1:0] bistsig
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by all-ones.
    localparam logic [PI_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? '1 : LFSR_SEED;
    localparam logic [15:0]     LAST_CNT = 16'(NUM_PATTERNS - 1);

    state_t          state_q, state_d;
    logic [PI_W-1:0] lfsr_q,  lfsr_d;
    logic [PO_W-1:0] misr_q,  misr_d;
    logic [15:0]     cnt_q,   cnt_d;
    logic            done_q,  done_d;
    logic            pass_q,  pass_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '1;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                pass_d = 1'b0;
                if (bistmode) begin
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                if (!bistmode) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_d  = SEED_EFF;
                    misr_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!bistmode) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_d = {lfsr_q[PI_W-2:0], lfsr_q[PI_W-1] ^ lfsr_q[PI_W-3]};
                    misr_d = {misr_q[PO_W-2:0], misr_q[PO_W-1] ^ misr_q[PO_W-10]} ^ cut_po;
                    // Saturate rather than wrap. A legal NUM_PATTERNS leaves RUN before saturation.
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    // The edge that leaves RUN still captures the last pattern's response.
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_COMPARE;
                    end
                end
            end

            ST_COMPARE: begin
                if (!bistmode) begin
                    state_d = ST_IDLE;
                end else begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result holds until bistmode drops. A fresh run needs a low-then-high cycle.
                if (!bistmode) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cut_pi   = (state_q == ST_RUN) ? lfsr_q : pi;
    assign bistdone = done_q;
    assign bistpass = pass_q;

`ifdef BIST_SIGOUT_EN
    assign bistsig = misr_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Purpose     : self-checking bench for bist_controller. It drives randomized CUT faults and aborts
//               and compares the results with a polynomial-arithmetic signature model.
// Latency     : all waits are fixed cycle counts, so the run always terminates.
// Backpressure: n/a
module tb_bist_controller;

    localparam int PI_W = 35;
    localparam int PO_W = 49;
    localparam int N_S  = 4;
    localparam int N_L  = 2000;
    localparam int N_M  = 300;
    localparam int NI   = 5;
    localparam longint unsigned PI_MASK = (64'd1 << PI_W) - 64'd1;
    localparam longint unsigned PO_MASK = (64'd1 << PO_W) - 64'd1;

    logic            clk;
    logic            rst;
    logic            bistmode;
    logic [PI_W-1:0] pi;

    // The fault model is shared by every instance. It ORs or_mask into every response and
    // XORs err_mask into the response of the one pattern equal to trig.
    logic [PO_W-1:0] or_mask;
    logic [PO_W-1:0] err_mask;
    logic [PI_W-1:0] trig;

    logic [PI_W-1:0] cut_pi [NI];
    logic [PO_W-1:0] cut_po [NI];
    logic            done   [NI];
    logic            pass   [NI];
`ifdef BIST_SIGOUT_EN
    logic [PO_W-1:0] sig    [NI];
`endif

    int total;
    int bad;

    for (genvar g = 0; g < NI; g++) begin : g_cut
        assign cut_po[g] = ({{(PO_W-PI_W){1'b0}}, cut_pi[g]} | or_mask)
                           ^ ((cut_pi[g] == trig) ? err_mask : '0);
    end

    // a/b: short runs (golden 0 / 1); c: default build; d/e: seed 0 vs seed all-ones.
    bist_controller #(.NUM_PATTERNS(N_S), .LFSR_SEED(35'h1), .GOLDEN_SIG(49'h0)) u_a (
        .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi[0]),
        .cut_po(cut_po[0]), .bistdone(done[0]), .bistpass(pass[0])
`ifdef BIST_SIGOUT_EN
        , .bistsig(sig[0])
`endif
    );
    bist_controller #(.NUM_PATTERNS(N_S), .LFSR_SEED(35'h1), .GOLDEN_SIG(49'h1)) u_b (
        .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi[1]),
        .cut_po(cut_po[1]), .bistdone(done[1]), .bistpass(pass[1])
`ifdef BIST_SIGOUT_EN
        , .bistsig(sig[1])
`endif
    );
    bist_controller u_c (
        .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi[2]),
        .cut_po(cut_po[2]), .bistdone(done[2]), .bistpass(pass[2])
`ifdef BIST_SIGOUT_EN
        , .bistsig(sig[2])
`endif
    );
    bist_controller #(.NUM_PATTERNS(N_M), .LFSR_SEED(35'h0)) u_d (
        .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi[3]),
        .cut_po(cut_po[3]), .bistdone(done[3]), .bistpass(pass[3])
`ifdef BIST_SIGOUT_EN
        , .bistsig(sig[3])
`endif
    );
    bist_controller #(.NUM_PATTERNS(N_M), .LFSR_SEED({PI_W{1'b1}})) u_e (
        .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi[4]),
        .cut_po(cut_po[4]), .bistdone(done[4]), .bistpass(pass[4])
`ifdef BIST_SIGOUT_EN
        , .bistsig(sig[4])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Polynomial model: pattern stream x^35+x^33+1, MISR x^49+x^40+1, arithmetic on 64-bit words.
    function automatic longint unsigned lfsr_step(input longint unsigned s);
        return ((s << 1) | (((s >> 34) ^ (s >> 32)) & 64'd1)) & PI_MASK;
    endfunction

    function automatic longint unsigned misr_inv(input longint unsigned m);
        return (m >> 1) | ((((m >> 40) ^ m) & 64'd1) << 48);
    endfunction

    function automatic logic [PO_W-1:0] model_sig(input logic [PI_W-1:0] seed, input int n);
        longint unsigned s, m, po;
        s = (seed == '0) ? PI_MASK : 64'(seed);
        m = 64'd0;
        for (int k = 0; k < n; k++) begin
            po = s | 64'(or_mask);
            if (s == 64'(trig)) po = po ^ 64'(err_mask);
            m = ((((m << 1) | (((m >> 48) ^ (m >> 39)) & 64'd1)) & PO_MASK) ^ po);
            s = lfsr_step(s);
        end
        return PO_W'(m);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts a short run at the next edge (E0). Iteration j is sampled after edge Ej.
    // When abort_at >= 0, the run is aborted at that iteration, by bistmode or by reset.
    task automatic run_short(input int abort_at, input bit by_reset);
        logic [PO_W-1:0] exp_sig;
        longint unsigned s;
        exp_sig  = model_sig(PI_W'(1), N_S);
        s        = 64'd1;
        bistmode = 1'b1;
        for (int j = 0; j <= N_S + 2; j++) begin
            tick();
            if (j >= 1 && j <= N_S) begin
                check("run_pat", cut_pi[0], s);
                s = lfsr_step(s);
            end
            check("done_a", done[0], j == N_S + 2);
            check("done_b", done[1], j == N_S + 2);
            if (j == N_S + 2) begin
                check("pass_a", pass[0], exp_sig == 49'h0);
                check("pass_b", pass[1], exp_sig == 49'h1);
                check("done_pi", cut_pi[0], pi);
`ifdef BIST_SIGOUT_EN
                check("sig_a", sig[0], exp_sig);
`endif
            end else begin
                check("pass_a_lo", pass[0], 1'b0);
            end
            if (j == abort_at) begin
                if (by_reset) begin
                    rst = 1'b0;
                    #1;
                    check("rst_done", done[0], 1'b0);
                    check("rst_pi", cut_pi[0], pi);
                    @(negedge clk);
                    rst = 1'b1;
                end else begin
                    bistmode = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        tick();
                        check("abort_done", done[0], 1'b0);
                        check("abort_pi", cut_pi[0], pi);
                    end
                end
                return;
            end
            pi = PI_W'({$urandom, $urandom});
        end
    endtask

    task automatic run_long();
        logic [PO_W-1:0] sig_c, sig_m;
        longint unsigned s1, sf;
        sig_c    = model_sig(PI_W'(1), N_L);
        sig_m    = model_sig('0, N_M);
        s1       = 64'd1;
        sf       = PI_MASK;
        bistmode = 1'b1;
        for (int j = 0; j <= N_L + 2; j++) begin
            tick();
            if (j >= 1 && j <= N_L) begin
                check("c_pat", cut_pi[2], s1);
                s1 = lfsr_step(s1);
            end
            if (j >= 1 && j <= N_M) begin
                check("d_pat", cut_pi[3], sf);
                check("e_pat", cut_pi[4], sf);
                sf = lfsr_step(sf);
            end
            check("c_done", done[2], j == N_L + 2);
            check("d_done", done[3], j >= N_M + 2);
            check("e_done", done[4], j >= N_M + 2);
            if (j == N_M + 2) begin
                check("d_pass", pass[3], sig_m == '0);
                check("e_pass", pass[4], sig_m == '0);
            end
            if (j == N_L + 2) check("c_pass", pass[2], sig_c == '0);
        end
    endtask

    // The result must hold while bistmode stays high, and clear after bistmode drops for one edge.
    task automatic finish_run(input int idx);
        tick();
        check("hold_done", done[idx], 1'b1);
        bistmode = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            check("clr_done", done[i], 1'b0);
            check("clr_pass", pass[i], 1'b0);
        end
    endtask

    initial begin
        int r;
        int k;
        longint unsigned p, e;
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        bistmode = 1'b0;
        pi       = '0;
        or_mask  = '0;
        err_mask = '0;
        trig     = '0;

        // Reset and system mode
        repeat (2) @(negedge clk);
        check("rst_done0", done[0], 1'b0);
        check("rst_pass0", pass[0], 1'b0);
        bistmode = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_done1", done[0], 1'b0);
        check("rst_pass1", pass[0], 1'b0);
        bistmode = 1'b0;
        pi       = 35'h5A5A5A5A5;
        #1;
        check("sys_pi_rst", cut_pi[0], 35'h5A5A5A5A5);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("sys_pi", cut_pi[0], 35'h5A5A5A5A5);
        check("sys_done", done[0], 1'b0);

        // Fault-free run
        run_short(-1, 1'b0);
        check("ff_pass", pass[0], 1'b1);
        check("ff_gold1", pass[1], 1'b0);
        finish_run(0);

        // Stuck-at-1 on cut_po[0]
        or_mask = 49'h1;
        run_short(-1, 1'b0);
        check("sa_pass", pass[0], 1'b0);
        finish_run(0);
        or_mask = '0;

        // Abort in RUN cycle 2, then a fresh run
        run_short(3, 1'b0);
        run_short(-1, 1'b0);
        check("abort_rerun_pass", pass[0], 1'b1);
        finish_run(0);

        // Reset pulse mid-RUN, then a fresh run
        run_short(3, 1'b1);
        run_short(-1, 1'b0);
        check("rst_rerun_pass", pass[0], 1'b1);
        finish_run(0);

        // Randomized faults and aborts
        for (int it = 0; it < 10; it++) begin
            or_mask  = ($urandom_range(0, 2) == 0) ? (49'h1 << $urandom_range(0, PO_W - 1)) : '0;
            err_mask = ($urandom_range(0, 1) == 0) ? PO_W'({$urandom, $urandom}) : '0;
            trig     = PI_W'(35'h1 << $urandom_range(0, N_S - 1));
            pi       = PI_W'({$urandom, $urandom});
            r        = $urandom_range(0, 3);
            if (r == 1 || r == 2) begin
                run_short($urandom_range(0, N_S + 1), r == 2);
            end
            run_short(-1, 1'b0);
            finish_run(0);
        end

        // Back-to-back default-length runs. The single-pattern error is chosen so that
        // u_c's signature cancels to zero. That exercises a passing long run.
        or_mask  = '0;
        err_mask = '0;
        k        = $urandom_range(0, N_L - 1);
        p        = 64'd1;
        for (int i = 0; i < k; i++) p = lfsr_step(p);
        trig     = PI_W'(p);
        e        = 64'(model_sig(PI_W'(1), N_L));
        for (int i = 0; i < N_L - 1 - k; i++) e = misr_inv(e);
        err_mask = PO_W'(e);
        run_long();
        check("b2b_pass1", pass[2], 1'b1);
        finish_run(2);
        run_long();
        check("b2b_pass2", pass[2], 1'b1);
        finish_run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
